// File: rtl/heptane_core_xlink.sv
// heptane_core_xlink: N-way committed-store broadcast between heptane cores.
// Every core's store record reaches every other core. Each source has a FIFO.
// Each destination lane picks one source per cycle by round-robin, with backpressure.
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   in_valid/in_ready      per-source handshake (slice i = core i)
//   in_data/in_lsq         per-source record payload and LSQ index
//   out_valid/out_ready    per-destination handshake (slice j = core j)
//   out_data/out_lsq       record delivered to destination j (0 when idle)
//   out_src                source core of the delivered record (0 when idle)

module heptane_core_xlink #(
    parameter int NCORE  = 4,
    parameter int DATA_W = 160,
    parameter int LSQ_W  = 9,
    parameter int DEPTH  = 4,
    parameter int SRC_W  = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NCORE-1:0]        in_valid,
    output logic [NCORE-1:0]        in_ready,
    input  logic [NCORE*DATA_W-1:0] in_data,
    input  logic [NCORE*LSQ_W-1:0]  in_lsq,
    output logic [NCORE-1:0]        out_valid,
    input  logic [NCORE-1:0]        out_ready,
    output logic [NCORE*DATA_W-1:0] out_data,
    output logic [NCORE*LSQ_W-1:0]  out_lsq,
    output logic [NCORE*SRC_W-1:0]  out_src
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [DATA_W-1:0] mem_data_q [NCORE][DEPTH];
    logic [LSQ_W-1:0]  mem_lsq_q  [NCORE][DEPTH];

    logic [PW-1:0]    rd_q   [NCORE];
    logic [PW-1:0]    rd_d   [NCORE];
    logic [PW-1:0]    wr_q   [NCORE];
    logic [PW-1:0]    wr_d   [NCORE];
    logic [CW-1:0]    cnt_q  [NCORE];
    logic [CW-1:0]    cnt_d  [NCORE];
    logic [NCORE-1:0] pend_q [NCORE];
    logic [NCORE-1:0] pend_d [NCORE];

    logic [SRC_W-1:0] rr_q   [NCORE];
    logic [SRC_W-1:0] rr_d   [NCORE];
    logic [SRC_W-1:0] lsrc_q [NCORE];
    logic [SRC_W-1:0] lsrc_d [NCORE];
    logic [NCORE-1:0] lock_q;
    logic [NCORE-1:0] lock_d;

    logic [NCORE-1:0] nonempty;
    logic [NCORE-1:0] push;
    logic [NCORE-1:0] pop;
    logic [NCORE-1:0] gnt_vld;
    logic [SRC_W-1:0] gnt_src [NCORE];

    // in_ready follows the registered count only, so a pop never
    // raises it in the same cycle.
    always_comb begin
        nonempty = '0;
        in_ready = '0;
        push     = '0;
        for (int s = 0; s < NCORE; s++) begin
            nonempty[s] = (cnt_q[s] != '0);
            in_ready[s] = !rst && (cnt_q[s] != FULL);
            push[s]     = in_valid[s] && in_ready[s];
        end
    end

    // Per-lane round-robin. Candidates at or above rr win over those
    // below it, and the lowest index wins within each group.
    always_comb begin
        logic             hi_v;
        logic             lo_v;
        logic [SRC_W-1:0] hi_s;
        logic [SRC_W-1:0] lo_s;
        gnt_vld = '0;
        hi_v    = 1'b0;
        lo_v    = 1'b0;
        hi_s    = '0;
        lo_s    = '0;
        for (int j = 0; j < NCORE; j++) begin
            gnt_src[j] = '0;
        end
        for (int j = 0; j < NCORE; j++) begin
            hi_v = 1'b0;
            lo_v = 1'b0;
            hi_s = '0;
            lo_s = '0;
            for (int s = NCORE - 1; s >= 0; s--) begin
                if (s != j && nonempty[s] && pend_q[s][j]) begin
                    if (SRC_W'(s) >= rr_q[j]) begin
                        hi_v = 1'b1;
                        hi_s = SRC_W'(s);
                    end else begin
                        lo_v = 1'b1;
                        lo_s = SRC_W'(s);
                    end
                end
            end
            // A stalled grant is held so the lane's output stays stable.
            if (lock_q[j]) begin
                gnt_vld[j] = 1'b1;
                gnt_src[j] = lsrc_q[j];
            end else if (hi_v) begin
                gnt_vld[j] = 1'b1;
                gnt_src[j] = hi_s;
            end else if (lo_v) begin
                gnt_vld[j] = 1'b1;
                gnt_src[j] = lo_s;
            end
        end
    end

    always_comb begin
        out_valid = '0;
        out_data  = '0;
        out_lsq   = '0;
        out_src   = '0;
        for (int j = 0; j < NCORE; j++) begin
            if (gnt_vld[j]) begin
                out_valid[j] = 1'b1;
                out_src[j*SRC_W +: SRC_W] = gnt_src[j];
                for (int s = 0; s < NCORE; s++) begin
                    if (gnt_src[j] == SRC_W'(s)) begin
                        out_data[j*DATA_W +: DATA_W] =
                            mem_data_q[s][rd_q[s]];
                        out_lsq[j*LSQ_W +: LSQ_W] =
                            mem_lsq_q[s][rd_q[s]];
                    end
                end
            end
        end
    end

    always_comb begin
        logic [NCORE-1:0] clr;
        logic [NCORE-1:0] left;
        logic [NCORE-1:0] mask;
        logic             load;
        clr  = '0;
        left = '0;
        mask = '0;
        load = 1'b0;
        pop  = '0;
        for (int s = 0; s < NCORE; s++) begin
            clr = '0;
            for (int j = 0; j < NCORE; j++) begin
                clr[j] = gnt_vld[j] && out_ready[j]
                         && (gnt_src[j] == SRC_W'(s));
            end
            left   = pend_q[s] & ~clr;
            // Retire the head once every destination has taken it.
            pop[s] = nonempty[s] && (clr != '0) && (left == '0);
            cnt_d[s] = cnt_q[s] + CW'(push[s]) - CW'(pop[s]);
            rd_d[s]  = rd_q[s] + PW'(pop[s]);
            wr_d[s]  = wr_q[s] + PW'(push[s]);
            // A new head arrives on push-into-empty or pop-leaving-data.
            load = (pop[s] || (push[s] && !nonempty[s]))
                   && (cnt_d[s] != '0);
            mask    = '1;
            mask[s] = 1'b0;
            pend_d[s] = load ? mask : left;
        end
        for (int j = 0; j < NCORE; j++) begin
            lock_d[j] = gnt_vld[j] && !out_ready[j];
            lsrc_d[j] = gnt_src[j];
            rr_d[j]   = rr_q[j];
            if (gnt_vld[j] && out_ready[j]) begin
                if (gnt_src[j] == SRC_W'(NCORE - 1)) begin
                    rr_d[j] = '0;
                end else begin
                    rr_d[j] = gnt_src[j] + SRC_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_q <= '0;
            for (int s = 0; s < NCORE; s++) begin
                rd_q[s]   <= '0;
                wr_q[s]   <= '0;
                cnt_q[s]  <= '0;
                pend_q[s] <= '0;
                rr_q[s]   <= '0;
                lsrc_q[s] <= '0;
            end
        end else begin
            lock_q <= lock_d;
            for (int s = 0; s < NCORE; s++) begin
                rd_q[s]   <= rd_d[s];
                wr_q[s]   <= wr_d[s];
                cnt_q[s]  <= cnt_d[s];
                pend_q[s] <= pend_d[s];
                rr_q[s]   <= rr_d[s];
                lsrc_q[s] <= lsrc_d[s];
            end
        end
    end

    // Payload storage needs no reset: reads are gated by the counts.
    always_ff @(posedge clk) begin
        for (int s = 0; s < NCORE; s++) begin
            if (push[s]) begin
                mem_data_q[s][wr_q[s]] <= in_data[s*DATA_W +: DATA_W];
                mem_lsq_q[s][wr_q[s]]  <= in_lsq[s*LSQ_W +: LSQ_W];
            end
        end
    end

endmodule

// File: doc/heptane_core_xlink.md
Name: heptane_core_xlink

Overview:
- N-way store-forwarding interconnect for a cluster of NCORE heptane cores.
- Generalises the fixed two-core cross-wired LSQ-write exchange (lsr_wr / p_LSQ / dc_wrEn).
- Each core broadcasts a committed store record to every other core in the cluster.
- Per-source FIFOs and per-destination round-robin arbitration with backpressure replace the old direct point-to-point wiring.

Parameters:
- NCORE, 4: number of cores in the cluster, 2..8.
- DATA_W, 160: width of the store record payload (lsaddr record).
- LSQ_W, 9: width of the LSQ entry index.
- DEPTH, 4: per-source FIFO depth; must be a power of two, at least 2.
- SRC_W, 3: width of the source-core ID; must satisfy 2^SRC_W >= NCORE.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous reset, active-high.
- in_valid  in  NCORE  store record offered by core i.
- in_ready  out  NCORE  FIFO i can accept a record.
- in_data  in  NCORE*DATA_W  payload, core i in slice i.
- in_lsq  in  NCORE*LSQ_W  LSQ index, core i in slice i.
- out_valid  out  NCORE  record presented to destination j.
- out_ready  in  NCORE  destination j accepts the record.
- out_data  out  NCORE*DATA_W  payload delivered to destination j.
- out_lsq  out  NCORE*LSQ_W  LSQ index delivered to destination j.
- out_src  out  NCORE*SRC_W  source core of the delivered record.

Behaviour:
- Clock and reset: all state is on clk. rst is asynchronous, active-high.
- Reset state: FIFOs empty, pending masks 0, RR pointers 0, grant locks clear. out_valid=0, out_data/out_lsq/out_src=0. in_ready=0 while rst is high, and all ones from the first cycle after deassertion.
- Push: a record is pushed into FIFO i when in_valid[i] && in_ready[i]. in_ready[i] = !full[i]; it is registered-count based and never depends on in_valid.
- Pending mask: each FIFO head owns pending[i][NCORE-1:0].
  - It is loaded with all-ones minus bit i whenever a new entry becomes head, i.e. on a push into an empty FIFO, or on a pop that leaves the FIFO non-empty.
  - A core never receives its own record.
- Candidates for destination j: every source s != j with a non-empty FIFO and pending[s][j]=1.
- Grant:
  - Round-robin starting at rr[j].
  - out_valid[j] = a grant exists.
  - out_data/out_lsq/out_src for j are driven combinationally from the granted FIFO head.
  - out_data/out_lsq/out_src are 0 when out_valid[j]=0.
- Grant lock: while out_valid[j] && !out_ready[j], the grant is held in lock[j]/lsrc[j]. Output remains stable and is not re-arbitrated even if higher-priority sources become ready.
- Transfer: a transfer occurs when out_valid[j] && out_ready[j]. On transfer:
  - clear pending[s][j];
  - set rr[j] = (s+1) mod NCORE;
  - release the lock.
  - rr[j] is unchanged when no transfer occurs.
- Multiple destinations may take the same head in one cycle; all their bits clear together.
- Pop: FIFO s pops in the cycle its pending mask becomes 0 after that cycle's clears.
  - Simultaneous push and pop on the same FIFO is legal, including when full. Occupancy is unchanged.
  - in_ready does not rise early on a pop-when-full; it follows the registered count.
- Latency: a record pushed in cycle t is visible on out_valid at cycle t+1 at the earliest (no bypass).
- Throughput: each destination takes one record per cycle. Each source retires at most one record per cycle.
- Pointers: FIFO rd/wr pointers are log2(DEPTH) bits with natural wrap. A separate occupancy counter of log2(DEPTH)+1 bits distinguishes full from empty.
- NCORE=2: degenerates to the pair exchange, core 0 to core 1 and core 1 to core 0, with buffering.
- Reset mid-operation: all in-flight entries are discarded. No partial delivery is reported after rst rises.

Test Plan:
1. Single broadcast. NCORE=4; after reset push core0 data=0xA5, lsq=3; all out_ready=1.
   - Required: next cycle out_valid=4'b1110, out_src=0 on lanes 1–3, out_lsq=3; lane 0 stays invalid.
   - Required: FIFO0 empty the following cycle.
2. FIFO full. All out_ready=0; core1 offers 5 records.
   - Required: 4 accepted, then in_ready[1]=0 and the 5th is held.
   - Then raise all ready: in_ready[1] returns to 1 one cycle after the first pop.
3. Round-robin. Cores 0, 1, 2 push one record each in the same cycle; only out_ready[3]=1.
   - Required: lane 3 delivers sources 0, 1, 2 on consecutive cycles; rr[3] ends at 3.
4. Grant lock. Core1 pushes while out_ready[2]=0, so lane 2 is granted src 1; next cycle core0 pushes (rr[2]=0).
   - Required: out_src[2] stays 1 until out_ready[2]=1; src 0 is delivered the cycle after.
5. Partial delivery. Core3 pushes; lanes 0 and 1 ready, lane 2 stalled 3 cycles.
   - Required: out_valid[0], out_valid[1] high for one cycle only.
   - Required: the entry remains head and pops in the cycle lane 2 accepts.
6. Reset mid-op. Fill FIFOs 0 and 2 with 2 entries each, then assert rst asynchronously between clock edges.
   - Required: out_valid=0 immediately; after deassertion all FIFOs are empty and in_ready=4'b1111.
